// File: rtl/uart_rx_frame_parser_if.sv
// Byte stream from the uart receiver and payload stream to the consumer.
// The parser takes the slave modport; the driving/consuming side takes master.
interface uart_rx_frame_parser_if;
  logic [7:0] rx_data_i;
  logic       rx_vld_i;
  logic       rx_rdy_o;
  logic [7:0] pl_data_o;
  logic       pl_vld_o;
  logic       pl_sop_o;
  logic       pl_eop_o;
  logic       pl_rdy_i;

  modport slave (
    input  rx_data_i, rx_vld_i, pl_rdy_i,
    output rx_rdy_o, pl_data_o, pl_vld_o, pl_sop_o, pl_eop_o
  );

  modport master (
    output rx_data_i, rx_vld_i, pl_rdy_i,
    input  rx_rdy_o, pl_data_o, pl_vld_o, pl_sop_o, pl_eop_o
  );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// Hunts for 55 AA LEN PAYLOAD CHK frames in the uart byte stream, forwards the payload
// through a one-deep registered stream and reports per-frame status plus saturating counters.
module uart_rx_frame_parser #(
  parameter int DLY            = 1,
  parameter int MAX_LEN        = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  uart_rx_frame_parser_if.slave         bus,
  output logic                          frm_ok_o,
  output logic                          frm_err_o,
  output logic [1:0]                    frm_err_code_o,
  output logic [15:0]                   ok_cnt_o,
  output logic [15:0]                   err_cnt_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // DLY is kept only so existing instantiations still bind; no delays are modelled.
  if (DLY < 0 || MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("uart_rx_frame_parser: illegal parameter value");
  end

  typedef enum logic [2:0] {S_IDLE, S_HDR2, S_LEN, S_PAYLOAD, S_CHK} state_t;

  state_t      state_q, state_d;
  logic [7:0]  len_q, len_d, sum_q, sum_d, cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]  pl_data_q, pl_data_d;
  logic        pl_vld_q, pl_vld_d, pl_sop_q, pl_sop_d, pl_eop_q, pl_eop_d;
  logic        ok_q, ok_d, err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic [15:0] ok_cnt_q, ok_cnt_d, err_cnt_q, err_cnt_d;
  logic        rx_rdy, accept, stall;
  logic [7:0]  b;

  assign rx_rdy = !(enable_i && state_q == S_PAYLOAD) || !pl_vld_q || bus.pl_rdy_i;
  assign accept = bus.rx_vld_i && rx_rdy;
  assign stall  = bus.rx_vld_i && !rx_rdy;
  assign b      = bus.rx_data_i;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    pl_data_d = pl_data_q;
    pl_vld_d  = pl_vld_q;
    pl_sop_d  = pl_sop_q;
    pl_eop_d  = pl_eop_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    ok_cnt_d  = ok_cnt_q;
    err_cnt_d = err_cnt_q;

    if (pl_vld_q && bus.pl_rdy_i) pl_vld_d = 1'b0;

    if (!enable_i) begin
      state_d = S_IDLE;
      tmo_d   = '0;
    end else begin
      if (accept || state_q == S_IDLE) tmo_d = '0;
      else if (!stall)                 tmo_d = tmo_q + 1'b1;

      if (accept) begin
        unique case (state_q)
          S_IDLE: if (b == 8'h55) state_d = S_HDR2;
          S_HDR2: begin
            if (b == 8'hAA)      state_d = S_LEN;
            else if (b != 8'h55) state_d = S_IDLE;
          end
          S_LEN: begin
            if (b == 8'h00 || b > 8'(MAX_LEN)) begin
              state_d = S_IDLE;
              err_d   = 1'b1;
              code_d  = 2'b01;
            end else begin
              len_d   = b;
              sum_d   = b;
              cnt_d   = '0;
              state_d = S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            pl_data_d = b;
            pl_vld_d  = 1'b1;
            pl_sop_d  = (cnt_q == 8'd0);
            pl_eop_d  = (cnt_q == len_q - 8'd1);
            sum_d     = sum_q + b;
            cnt_d     = cnt_q + 8'd1;
            if (cnt_q == len_q - 8'd1) state_d = S_CHK;
          end
          S_CHK: begin
            state_d = S_IDLE;
            if (b == sum_q) ok_d = 1'b1;
            else begin
              err_d  = 1'b1;
              code_d = 2'b10;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end else if (state_q != S_IDLE && !stall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        // An accepted byte takes priority over an expiring count (handled above).
        state_d = S_IDLE;
        err_d   = 1'b1;
        code_d  = 2'b11;
        tmo_d   = '0;
      end
    end

    if (ok_d && ok_cnt_q != '1)   ok_cnt_d  = ok_cnt_q + 16'd1;
    if (err_d && err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      pl_data_q <= '0;
      pl_vld_q  <= 1'b0;
      pl_sop_q  <= 1'b0;
      pl_eop_q  <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= '0;
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      pl_data_q <= pl_data_d;
      pl_vld_q  <= pl_vld_d;
      pl_sop_q  <= pl_sop_d;
      pl_eop_q  <= pl_eop_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      code_q    <= code_d;
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.rx_rdy_o  = rx_rdy;
  assign bus.pl_data_o = pl_data_q;
  assign bus.pl_vld_o  = pl_vld_q;
  assign bus.pl_sop_o  = pl_sop_q;
  assign bus.pl_eop_o  = pl_eop_q;
  assign frm_ok_o       = ok_q;
  assign frm_err_o      = err_q;
  assign frm_err_code_o = code_q;
  assign ok_cnt_o       = ok_cnt_q;
  assign err_cnt_o      = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Directed bench for uart_rx_frame_parser: hand-computed frames, payload scoreboard,
// status pulses, backpressure, timeout latency and async reset.
module tb_uart_rx_frame_parser;
  logic        clk = 1'b0;
  logic        rst, en;
  logic        frm_ok, frm_err;
  logic [1:0]  frm_code;
  logic [15:0] ok_cnt, err_cnt;

  always #5 clk = ~clk;

  uart_rx_frame_parser_if bus ();

  uart_rx_frame_parser #(.DLY(1), .MAX_LEN(64), .TIMEOUT_CYCLES(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (en),
    .bus            (bus),
    .frm_ok_o       (frm_ok),
    .frm_err_o      (frm_err),
    .frm_err_code_o (frm_code),
    .ok_cnt_o       (ok_cnt),
    .err_cnt_o      (err_cnt)
  );

  int n_tests = 0, n_fail = 0;
  int ok_pulses = 0, err_pulses = 0, viol = 0, stalls = 0, bp_cyc = 0;
  bit bp_mode = 1'b0;
  logic [9:0] rcv[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the last byte was accepted.
  task automatic send_frame(input logic [63:0] v, input int n);
    logic acc;
    for (int i = 0; i < n; i++) begin
      bus.rx_data_i = v[8*(n-1-i) +: 8];
      bus.rx_vld_i  = 1'b1;
      acc = 1'b0;
      for (int k = 0; k < 200 && !acc; k++) begin
        @(negedge clk);
        acc = bus.rx_rdy_o;
        @(posedge clk);
        #1;
      end
      bus.rx_vld_i = 1'b0;
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic check_stream(input logic [63:0] pv, input int n, input bit trunc);
    logic [9:0] e;
    chk("pl_count", rcv.size(), n);
    for (int i = 0; i < n && i < rcv.size(); i++) begin
      e = {(i == n-1) && !trunc, i == 0, pv[8*(n-1-i) +: 8]};
      chk("pl_byte", {22'd0, rcv[i]}, {22'd0, e});
    end
    rcv.delete();
  endtask

  // Monitor: sampled mid-cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.pl_vld_o && bus.pl_rdy_i) rcv.push_back({bus.pl_eop_o, bus.pl_sop_o, bus.pl_data_o});
      if (frm_ok)  ok_pulses++;
      if (frm_err) err_pulses++;
      if (!bus.rx_rdy_o) begin
        if (bus.pl_vld_o && !bus.pl_rdy_i) stalls++;
        else viol++;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (bp_mode) begin
      bp_cyc++;
      bus.pl_rdy_i = (bp_cyc % 3 == 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1; en = 1'b1;
    bus.rx_data_i = '0; bus.rx_vld_i = 1'b0; bus.pl_rdy_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pl_vld", bus.pl_vld_o, 0);
    chk("rst_ok",     frm_ok, 0);
    chk("rst_err",    frm_err, 0);
    chk("rst_code",   frm_code, 0);
    chk("rst_okcnt",  ok_cnt, 0);
    chk("rst_errcnt", err_cnt, 0);
    chk("rst_rx_rdy", bus.rx_rdy_o, 1);
    rst = 1'b0;
    idle(1);

    // Good frame; checksum covers LEN + payload: 03+11+22+33 = 69
    send_frame(64'h55AA0311, 4);
    chk("lat_vld", bus.pl_vld_o, 1);
    chk("lat_data", bus.pl_data_o, 8'h11);
    chk("lat_sop", bus.pl_sop_o, 1);
    send_frame(64'h223369, 3);
    idle(4);
    check_stream(64'h112233, 3, 0);
    chk("good_okp", ok_pulses, 1);
    chk("good_okcnt", ok_cnt, 1);
    chk("good_errp", err_pulses, 0);

    // Bad checksum: 02+01+02 = 05, sent 00
    send_frame(64'h55AA02010200, 6);
    idle(4);
    check_stream(64'h0102, 2, 0);
    chk("badsum_errp", err_pulses, 1);
    chk("badsum_code", frm_code, 2'b10);
    chk("badsum_errcnt", err_cnt, 1);

    // Bad lengths 0 and 65
    send_frame(64'h55AA00, 3);
    send_frame(64'h55AA41, 3);
    idle(4);
    check_stream(64'h0, 0, 0);
    chk("badlen_errp", err_pulses, 3);
    chk("badlen_code", frm_code, 2'b01);
    chk("badlen_errcnt", err_cnt, 3);

    // Preamble resync
    send_frame(64'h5555AA017F80, 6);
    idle(4);
    check_stream(64'h7F, 1, 0);
    chk("resync1_okcnt", ok_cnt, 2);
    send_frame(64'h1255AA017F80, 6);
    idle(4);
    check_stream(64'h7F, 1, 0);
    chk("resync2_okcnt", ok_cnt, 3);

    // Backpressure: 04+01+02+03+04 = 0E
    stalls = 0;
    bp_mode = 1'b1;
    send_frame(64'h55AA04010203040E, 8);
    idle(12);
    bp_mode = 1'b0;
    bus.pl_rdy_i = 1'b1;
    idle(4);
    check_stream(64'h01020304, 4, 0);
    chk("bp_okp", ok_pulses, 4);
    chk("bp_errp", err_pulses, 3);
    chk("bp_stalled", stalls != 0, 1);

    // Timeout 16 cycles after the last accepted byte
    send_frame(64'h55AA0401, 4);
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (frm_err) lat = k - 1;
    end
    idle(1);
    chk("tmo_latency", lat, 16);
    idle(3);
    check_stream(64'h01, 1, 1);
    chk("tmo_code", frm_code, 2'b11);
    chk("tmo_errcnt", err_cnt, 4);

    send_frame(64'h55AA017F80, 5);
    idle(4);
    check_stream(64'h7F, 1, 0);
    chk("after_tmo_okcnt", ok_cnt, 5);

    // Disabled parser discards everything
    en = 1'b0;
    send_frame(64'h55AA017F80, 5);
    idle(4);
    check_stream(64'h0, 0, 0);
    chk("dis_okcnt", ok_cnt, 5);
    en = 1'b1;
    idle(1);

    // Async reset mid-frame with a pending payload byte
    bus.pl_rdy_i = 1'b0;
    send_frame(64'h55AA0311, 4);
    chk("mid_pending", bus.pl_vld_o, 1);
    rst = 1'b1;
    #2;
    chk("mrst_pl_vld", bus.pl_vld_o, 0);
    chk("mrst_okcnt", ok_cnt, 0);
    chk("mrst_errcnt", err_cnt, 0);
    chk("mrst_code", frm_code, 0);
    idle(1);
    rst = 1'b0;
    bus.pl_rdy_i = 1'b1;
    rcv.delete();
    idle(1);
    send_frame(64'h55AA017F80, 5);
    idle(4);
    check_stream(64'h7F, 1, 0);
    chk("post_rst_okcnt", ok_cnt, 1);

    chk("rdy_rule", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
